// File: rtl/seq_det_session_ctrl.sv
// Session controller for the serial run-of-ones detector: latches a config on start,
// tracks consecutive 1s on x, counts detect cycles and ends on target, timeout or abort.
module seq_det_session_ctrl #(
    parameter int unsigned RUN_W = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TO_W  = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             abort,
    input  logic [RUN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             x,
    input  logic             ack,
    output logic             busy,
    output logic             det,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             timed_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        DONE   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [RUN_W-1:0] len_q, len_d, eff_len;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic [TO_W-1:0]  timeout_q, timeout_d;
    logic             to_q, to_d;
    logic             det_i;
    logic [CNT_W:0]   match_inc;

    // A programmed length of 0 behaves as a run of one.
    assign eff_len   = (len_q == '0) ? RUN_W'(1) : len_q;
    assign det_i     = (state_q == RUN) && (run_cnt_q == eff_len);
    assign match_inc = {1'b0, match_q} + (CNT_W+1)'(1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
            len_q     <= '0;
            match_q   <= '0;
            target_q  <= '0;
            timer_q   <= '0;
            timeout_q <= '0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            len_q     <= len_d;
            match_q   <= match_d;
            target_q  <= target_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            to_q      <= to_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        len_d     = len_q;
        match_d   = match_q;
        target_d  = target_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        to_d      = to_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = cfg_len;
                    target_d  = cfg_target;
                    timeout_d = cfg_timeout;
                    run_cnt_d = '0;
                    timer_d   = '0;
                    match_d   = '0;
                    to_d      = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Abort freezes every counter so the host reads the pre-abort tally.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (!x)
                        run_cnt_d = '0;
                    else if (run_cnt_q >= eff_len)
                        run_cnt_d = eff_len;
                    else
                        run_cnt_d = run_cnt_q + RUN_W'(1);
                    if (det_i && (match_q != '1))
                        match_d = match_q + CNT_W'(1);
                    timer_d = timer_q + TO_W'(1);
                    if ((target_q != '0) && det_i && (match_inc == {1'b0, target_q})) begin
                        state_d = DONE;
                        to_d    = 1'b0;
                    end else if ((timeout_q != '0) && (timer_q == timeout_q - TO_W'(1))) begin
                        state_d = DONE;
                        to_d    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign det       = det_i;
    assign match_cnt = match_q;
    assign done      = (state_q == DONE);
    assign timed_out = (state_q == DONE) && to_q;

endmodule

// File: tb/tb_seq_det_session_ctrl.sv
// Bench for seq_det_session_ctrl: directed scenarios plus random sessions, all checked
// cycle by cycle against an integer-level model of the session rules.
module tb_seq_det_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start, abort, x, ack;
    logic [3:0]  cfg_len;
    logic [7:0]  cfg_target;
    logic [15:0] cfg_timeout;
    logic        busy, det, done, timed_out;
    logic [7:0]  match_cnt;
    logic [11:0] obs;

    int checks = 0;
    int errors = 0;

    seq_det_session_ctrl #(.RUN_W(4), .CNT_W(8), .TO_W(16)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
        .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
        .x(x), .ack(ack), .busy(busy), .det(det), .match_cnt(match_cnt),
        .done(done), .timed_out(timed_out)
    );

    always #5 clk = ~clk;
    assign obs = {busy, det, done, timed_out, match_cnt};

    // Model: phase 0 idle, 1 running, 2 finished; ones is the unbounded length of the current 1-run.
    int m_phase, m_ones, m_len, m_target, m_timeout, m_cycles, m_matches;
    bit m_to;

    function automatic void model_reset();
        m_phase = 0; m_ones = 0; m_len = 1; m_target = 0; m_timeout = 0;
        m_cycles = 0; m_matches = 0; m_to = 0;
    endfunction

    function automatic bit model_det();
        return (m_phase == 1) && (m_ones >= m_len);
    endfunction

    function automatic logic [11:0] model_out();
        int mc;
        mc = (m_matches > 255) ? 255 : m_matches;
        return {m_phase != 0, model_det(), m_phase == 2, (m_phase == 2) && m_to, 8'(mc)};
    endfunction

    function automatic void model_edge();
        bit d;
        d = model_det();
        if (m_phase == 0) begin
            if (start) begin
                m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
                m_target = int'(cfg_target); m_timeout = int'(cfg_timeout);
                m_ones = 0; m_cycles = 0; m_matches = 0; m_to = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (abort) m_phase = 0;
            else begin
                m_ones = x ? m_ones + 1 : 0;
                if (d) m_matches++;
                m_cycles++;
                if (m_target != 0 && d && m_matches == m_target) begin
                    m_phase = 2; m_to = 0;
                end else if (m_timeout != 0 && m_cycles == m_timeout) begin
                    m_phase = 2; m_to = 1;
                end
            end
        end else if (ack) m_phase = 0;
    endfunction

    task automatic drive(input bit s, input bit a, input bit xb, input bit k);
        start = s; abort = a; x = xb; ack = k;
    endtask

    task automatic set_cfg(input int len, input int tgt, input int tmo);
        cfg_len = 4'(len); cfg_target = 8'(tgt); cfg_timeout = 16'(tmo);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        drive(0, 0, 0, 0);
        set_cfg(0, 0, 0);
        model_reset();
        #12;
        if (obs !== 12'h000) begin errors++; $display("FAIL reset got=%h exp=%h", obs, 12'h000); end
        checks++;
        @(posedge clk); #1;
        rst_b = 1'b1;
        tick();
        if (obs !== model_out()) begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs, model_out()); end
        checks++;
    endtask

    task automatic test_basic();
        int dets = 0;
        set_cfg(2, 3, 0);
        drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0);
        if (obs !== model_out() || busy !== 1'b1) begin errors++; $display("FAIL basic_start got=%h exp=%h", obs, model_out()); end
        checks++;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0); tick();
            if (det === 1'b1) dets++;
            if (obs !== model_out()) begin errors++; $display("FAIL basic_run cyc=%0d got=%h exp=%h", i, obs, model_out()); end
            checks++;
        end
        if (dets != 3 || match_cnt !== 8'd3 || done !== 1'b1 || timed_out !== 1'b0) begin
            errors++; $display("FAIL basic_end dets=%0d cnt=%0d done=%b to=%b exp 3/3/1/0", dets, match_cnt, done, timed_out);
        end
        checks++;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0); tick();
            if (obs !== model_out() || done !== 1'b1) begin errors++; $display("FAIL basic_hold cyc=%0d got=%h exp=%h", i, obs, model_out()); end
            checks++;
        end
        drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
        if (obs !== model_out() || done !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'd3) begin
            errors++; $display("FAIL basic_ack got=%h exp=%h", obs, model_out());
        end
        checks++;
    endtask

    task automatic test_run_break();
        logic [6:0] pat;
        int dets = 0;
        bit saw_done = 0;
        pat = 7'b0111011;
        set_cfg(3, 0, 0);
        drive(1, 0, 0, 0); tick();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, pat[i], 0); tick();
            if (det === 1'b1) dets++;
            if (done === 1'b1) saw_done = 1;
            if (i == 5 && det !== 1'b1) begin errors++; $display("FAIL break_det6 got=%b exp=1", det); end
            if (i == 5) checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL break_run cyc=%0d got=%h exp=%h", i, obs, model_out()); end
            checks++;
        end
        drive(0, 1, 0, 0); tick(); drive(0, 0, 0, 0);
        if (done === 1'b1) saw_done = 1;
        if (dets != 1 || match_cnt !== 8'd1 || busy !== 1'b0 || saw_done) begin
            errors++; $display("FAIL break_end dets=%0d cnt=%0d busy=%b done_seen=%0d exp 1/1/0/0", dets, match_cnt, busy, saw_done);
        end
        checks++;
    endtask

    task automatic test_timeout();
        set_cfg(2, 4, 5);
        drive(1, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0);
            if (done !== 1'b0) begin errors++; $display("FAIL timeout_early cyc=%0d done=%b exp=0", i, done); end
            checks++;
            tick();
            if (obs !== model_out()) begin errors++; $display("FAIL timeout_run cyc=%0d got=%h exp=%h", i, obs, model_out()); end
            checks++;
        end
        if (done !== 1'b1 || timed_out !== 1'b1 || match_cnt !== 8'd0) begin
            errors++; $display("FAIL timeout_end done=%b to=%b cnt=%0d exp 1/1/0", done, timed_out, match_cnt);
        end
        checks++;
        drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    endtask

    task automatic test_tie();
        // Target reached on the very edge the timer expires: the target exit wins.
        set_cfg(1, 5, 6);
        drive(1, 0, 0, 0); tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 0); tick();
            if (obs !== model_out()) begin errors++; $display("FAIL tie_run cyc=%0d got=%h exp=%h", i, obs, model_out()); end
            checks++;
        end
        if (done !== 1'b1 || timed_out !== 1'b0 || match_cnt !== 8'd5) begin
            errors++; $display("FAIL tie_end done=%b to=%b cnt=%0d exp 1/0/5", done, timed_out, match_cnt);
        end
        checks++;
        drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    endtask

    task automatic test_ignored();
        set_cfg(0, 0, 8);
        drive(1, 0, 0, 1); tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'($urandom_range(0, 1)), 0, 1, 1'($urandom_range(0, 1)));
            set_cfg($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 3));
            tick();
            if (obs !== model_out()) begin errors++; $display("FAIL ignored_run cyc=%0d got=%h exp=%h", i, obs, model_out()); end
            checks++;
        end
        if (done !== 1'b1 || timed_out !== 1'b1 || match_cnt !== 8'd7) begin
            errors++; $display("FAIL ignored_end done=%b to=%b cnt=%0d exp 1/1/7", done, timed_out, match_cnt);
        end
        checks++;
        drive(1, 1, 0, 0); tick();
        if (obs !== model_out() || done !== 1'b1) begin errors++; $display("FAIL ignored_done got=%h exp=%h", obs, model_out()); end
        checks++;
        drive(1, 0, 0, 1); tick(); drive(0, 0, 0, 0);
        if (obs !== model_out() || busy !== 1'b0) begin errors++; $display("FAIL ignored_ack got=%h exp=%h", obs, model_out()); end
        checks++;
    endtask

    task automatic test_reset_mid();
        set_cfg(1, 0, 0);
        drive(1, 0, 0, 0); tick();
        for (int i = 0; i < 8; i++) begin drive(0, 0, 1, 0); tick(); end
        if (det !== 1'b1 || match_cnt !== 8'd7 || obs !== model_out()) begin
            errors++; $display("FAIL resetmid_pre det=%b cnt=%0d exp 1/7", det, match_cnt);
        end
        checks++;
        #2 rst_b = 1'b0;
        #1;
        if (obs !== 12'h000) begin errors++; $display("FAIL resetmid_async got=%h exp=%h", obs, 12'h000); end
        checks++;
        model_reset();
        @(posedge clk); #1;
        rst_b = 1'b1;
        set_cfg(2, 2, 0);
        drive(1, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0); tick();
            if (obs !== model_out()) begin errors++; $display("FAIL resetmid_after cyc=%0d got=%h exp=%h", i, obs, model_out()); end
            checks++;
        end
        drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            set_cfg($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 15));
            tick();
            if (obs !== model_out()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, model_out()); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_run_break();
        test_timeout();
        test_tie();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
